// File: rtl/parity_rx_pkg.sv
// Shared types and helpers for the XOR-parity serial receiver.
// Holds the FSM state enum, default geometry and the parity helper.
package parity_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int MAX_DATA_BITS    = 9;
  localparam int DEF_TMR_W        = $clog2(DEF_CLKS_PER_BIT);
  localparam int DEF_CNT_W        = $clog2(DEF_DATA_BITS + 1);

  // Zero-extension to MAX_DATA_BITS leaves the XOR unchanged.
  function automatic logic even_parity(
    input logic [MAX_DATA_BITS-1:0] vec
  );
    return ^vec;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: half_tick at CLKS_PER_BIT/2, full_tick at CLKS_PER_BIT.
// Ports: i_clk, i_rst_n (sync, low), i_clr, i_en, o_half_tick, o_full_tick.
module bit_timer
  import parity_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TMR_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_half_tick,
  output logic o_full_tick
);

  logic [TMR_W-1:0] r_cnt;
  logic             w_half;
  logic             w_full;

  assign w_half = i_en &&
    (r_cnt == TMR_W'(CLKS_PER_BIT/2 - 1));
  assign w_full = i_en &&
    (r_cnt == TMR_W'(CLKS_PER_BIT - 1));

  assign o_half_tick = w_half;
  assign o_full_tick = w_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_full) r_cnt <= '0;
      else        r_cnt <= r_cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/parity_serial_rx.sv
// XOR-parity serial receiver: start, DATA_BITS LSB-first, parity, stop.
// Ports: clk, rst_n (sync, low), rxd -> data_out, data_valid,
// parity_err, frame_err, busy. Define PARITY_ODD_EN for odd parity.
module parity_serial_rx
  import parity_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  rx_state_t              r_state;
  rx_state_t              w_next;
  logic [DATA_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_pbit;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;

  logic                   w_half;
  logic                   w_full;
  logic                   w_clr;
  logic                   w_en;
  logic                   w_last;
  logic                   w_perr;
  logic [MAX_DATA_BITS-1:0] w_par_vec;

  // Timer restarts on the start edge and again at mid-start,
  // so every later full tick lands mid-bit.
  assign w_clr = (r_state == IDLE) ||
                 ((r_state == START) && w_half);
  assign w_en  = (r_state != IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clr       (w_clr),
    .i_en        (w_en),
    .o_half_tick (w_half),
    .o_full_tick (w_full)
  );

  assign w_last = (r_bit_cnt == CNT_W'(DATA_BITS - 1));

  assign w_par_vec = MAX_DATA_BITS'(r_shift);

`ifdef PARITY_ODD_EN
  assign w_perr = ~(even_parity(w_par_vec) ^ r_pbit);
`else
  assign w_perr = even_parity(w_par_vec) ^ r_pbit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (!rxd) w_next = START;
      START:
        if (w_half) w_next = rxd ? IDLE : DATA;
      DATA:
        if (w_full && w_last) w_next = PARITY;
      PARITY:
        if (w_full) w_next = STOP;
      STOP:
        if (w_full) w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_pbit    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!rxd) r_bit_cnt <= '0;
        end
        DATA: begin
          if (w_full) begin
            r_shift   <= {rxd, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (w_full) r_pbit <= rxd;
        end
        STOP: begin
          // Errors are advisory: payload is delivered regardless.
          if (w_full) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
            r_perr  <= w_perr;
            r_ferr  <= ~rxd;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed self-checking bench for parity_serial_rx.
// CLKS_PER_BIT=16, DATA_BITS=8; honours PARITY_ODD_EN.
module tb_parity_serial_rx;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int LAT   = CPB/2 + (DB+2)*CPB + 1;
  localparam int FRAME = (DB+3)*CPB;

`ifdef PARITY_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_start = 0;

  int            p_cyc[$];
  logic [DB-1:0] p_dat[$];
  logic          p_pe[$];
  logic          p_fe[$];

  parity_serial_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (data_valid) begin
      p_cyc.push_back(cyc);
      p_dat.push_back(data_out);
      p_pe.push_back(parity_err);
      p_fe.push_back(frame_err);
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [DB-1:0] d,
    input logic          pb,
    input logic          sb
  );
    rxd = 1'b0;
    t_start = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = pb;
    repeat (CPB) @(negedge clk);
    rxd = sb;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic run_frame(
    input string         tag,
    input logic [DB-1:0] d,
    input logic          pb,
    input logic          sb,
    input logic          exp_pe,
    input logic          exp_fe
  );
    int base;
    base = p_cyc.size();
    send_frame(d, pb, sb);
    check({tag, "_npulse"}, p_cyc.size(), base + 1);
    if (p_cyc.size() > base) begin
      check({tag, "_lat"}, p_cyc[base] - t_start + 1, LAT);
      check({tag, "_data"}, p_dat[base], d);
      check({tag, "_perr"}, p_pe[base], exp_pe);
      check({tag, "_ferr"}, p_fe[base], exp_fe);
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(5);

    // 1: clean frame, exact pulse position
    run_frame("t1", 8'hA5, 1'b0, 1'b1, ODD, 1'b0);
    idle(4);
    check("t1_hold", data_out, 8'hA5);
    check("t1_vdrop", data_valid, 0);
    idle(10);

    // 2: parity mismatch
    run_frame("t2", 8'h01, 1'b0, 1'b1, ~ODD, 1'b0);
    idle(20);

    // 3: framing error
    run_frame("t3", 8'h3C, 1'b0, 1'b0, ODD, 1'b1);
    idle(30);
    check("t3_busy_after", busy, 0);

    // 4: 4-cycle glitch rejected, then clean frame
    base = p_cyc.size();
    rxd = 1'b0;
    @(negedge clk);
    check("t4_busy_hi", busy, 1);
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_busy_lo", busy, 0);
    idle(30);
    check("t4_nopulse", p_cyc.size(), base);
    run_frame("t4b", 8'h5A, 1'b0, 1'b1, ODD, 1'b0);
    idle(20);

    // 5: reset mid-DATA abandons frame
    base = p_cyc.size();
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rst_data", data_out, 0);
    check("t5_rst_perr", parity_err, 0);
    check("t5_rst_ferr", frame_err, 0);
    check("t5_rst_busy", busy, 0);
    idle(200);
    check("t5_nopulse", p_cyc.size(), base);
    run_frame("t5b", 8'h81, 1'b0, 1'b1, ODD, 1'b0);
    idle(20);

    // 6: back-to-back frames, no idle gap
    base = p_cyc.size();
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    idle(10);
    check("t6_npulse", p_cyc.size(), base + 2);
    if (p_cyc.size() >= base + 2) begin
      check("t6_gap", p_cyc[base+1] - p_cyc[base], FRAME);
      check("t6_d0", p_dat[base], 8'h12);
      check("t6_d1", p_dat[base+1], 8'h34);
      check("t6_pe0", p_pe[base], ODD);
      check("t6_pe1", p_pe[base+1], ODD);
      check("t6_fe1", p_fe[base+1], 0);
    end

    // 7: line stuck low keeps retriggering, no lockup
    base = p_cyc.size();
    rxd = 1'b0;
    repeat (400) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("t7_npulse", p_cyc.size(), base + 3);
    if (p_cyc.size() >= base + 2) begin
      check("t7_fe0", p_fe[base], 1);
      check("t7_fe1", p_fe[base+1], 1);
      check("t7_d0", p_dat[base], 0);
      check("t7_period", p_cyc[base+1] - p_cyc[base], LAT);
    end
    check("t7_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
